// File: rtl/ysyx_23060136_wb_csr_file_pkg.sv
// Shared definitions for the WB-stage machine-mode CSR file: CSR addresses,
// mstatus field positions, reset/constant defaults and the redirect FSM states.
package ysyx_23060136_CSR_PKG;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] MSTATUS_RST_DEF = 32'h0000_1800;
  localparam logic [31:0] MVENDORID_DEF   = 32'h7973_7978;
  localparam logic [31:0] MARCHID_DEF     = 32'h015F_DEA8;
  localparam logic [31:0] ECALL_CAUSE_DEF = 32'd11;

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } csr_state_e;

  // One-hot decode of the CSR address space.
  typedef struct packed {
    logic mstatus;
    logic mtvec;
    logic mepc;
    logic mcause;
    logic mvendorid;
    logic marchid;
  } csr_sel_t;

  function automatic logic [31:0] align4(input logic [31:0] v);
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060136_wb_csr_file_if.sv
// WB commit / EXU read / redirect signals of the CSR file, bundled as one interface.
interface ysyx_23060136_wb_csr_file_if;
  logic        WB_valid;
  logic        WB_ready;
  logic [11:0] WB_csr_addr;
  logic [31:0] WB_csr_wdata;
  logic        WB_rv32_csrrw;
  logic        WB_rv32_csrrs;
  logic        WB_rv32_ecall;
  logic        WB_rv32_mret;
  logic [11:0] EXU_csr_raddr;
  logic [31:0] EXU_csr_rdata;
  logic        CSR_illegal;
  logic        CSR_redirect_valid;
  logic [31:0] CSR_redirect_pc;

  modport slave (
    input  WB_valid, WB_csr_addr, WB_csr_wdata,
    input  WB_rv32_csrrw, WB_rv32_csrrs, WB_rv32_ecall, WB_rv32_mret,
    input  EXU_csr_raddr,
    output WB_ready, EXU_csr_rdata, CSR_illegal, CSR_redirect_valid, CSR_redirect_pc
  );

  modport master (
    output WB_valid, WB_csr_addr, WB_csr_wdata,
    output WB_rv32_csrrw, WB_rv32_csrrs, WB_rv32_ecall, WB_rv32_mret,
    output EXU_csr_raddr,
    input  WB_ready, EXU_csr_rdata, CSR_illegal, CSR_redirect_valid, CSR_redirect_pc
  );
endinterface

// File: rtl/ysyx_23060136_wb_csr_decode.sv
// Combinational CSR address decode: one-hot select plus writable/mapped flags.
module ysyx_23060136_wb_csr_decode
  import ysyx_23060136_CSR_PKG::*;
(
  input  logic [11:0] addr,
  output csr_sel_t    sel,
  output logic        writable,
  output logic        mapped
);

  // NOTE: every output of a combinational block gets a default before the
  // case, so an unlisted address can never leave a value held (latch).
  always_comb begin
    sel = '0;
    case (addr)
      CSR_MSTATUS:   sel.mstatus   = 1'b1;
      CSR_MTVEC:     sel.mtvec     = 1'b1;
      CSR_MEPC:      sel.mepc      = 1'b1;
      CSR_MCAUSE:    sel.mcause    = 1'b1;
      CSR_MVENDORID: sel.mvendorid = 1'b1;
      CSR_MARCHID:   sel.marchid   = 1'b1;
      default:       ;
    endcase
    writable = sel.mstatus | sel.mtvec | sel.mepc | sel.mcause;
    mapped   = writable | sel.mvendorid | sel.marchid;
  end

endmodule

// File: rtl/ysyx_23060136_wb_csr_file.sv
// Machine-mode CSR file at WB: csrrw/csrrs/ecall/mret commit, forwarded
// combinational reads for EXU, and a registered one-cycle PC redirect.
module ysyx_23060136_wb_csr_file
  import ysyx_23060136_CSR_PKG::*;
#(
  parameter logic [31:0] MSTATUS_RST = MSTATUS_RST_DEF,
  parameter logic [31:0] MVENDORID   = MVENDORID_DEF,
  parameter logic [31:0] MARCHID     = MARCHID_DEF,
  parameter logic [31:0] ECALL_CAUSE = ECALL_CAUSE_DEF
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_23060136_wb_csr_file_if.slave  bus
);

  csr_state_e  state_q, state_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        illegal_q, illegal_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  csr_sel_t    wsel, rsel;
  logic        wr_writable, wr_mapped, rd_writable, rd_mapped;

  ysyx_23060136_wb_csr_decode u_wr_decode (
    .addr     (bus.WB_csr_addr),
    .sel      (wsel),
    .writable (wr_writable),
    .mapped   (wr_mapped)
  );

  ysyx_23060136_wb_csr_decode u_rd_decode (
    .addr     (bus.EXU_csr_raddr),
    .sel      (rsel),
    .writable (rd_writable),
    .mapped   (rd_mapped)
  );

  logic        fire, ecall_fire, mret_fire, wr_en, wr_ok;
  logic [31:0] wr_value, ecall_mepc;

  assign bus.WB_ready = (state_q == IDLE);
  assign fire         = bus.WB_valid & bus.WB_ready;
  // ecall dominates; mret dominates a plain CSR write.
  assign ecall_fire   = fire & bus.WB_rv32_ecall;
  assign mret_fire    = fire & bus.WB_rv32_mret & ~bus.WB_rv32_ecall;
  assign wr_en        = fire & (bus.WB_rv32_csrrw | bus.WB_rv32_csrrs)
                             & ~bus.WB_rv32_ecall & ~bus.WB_rv32_mret;
  assign wr_ok        = wr_en & wr_writable;
  assign wr_value     = (wsel.mtvec | wsel.mepc) ? align4(bus.WB_csr_wdata) : bus.WB_csr_wdata;
  assign ecall_mepc   = align4(bus.WB_csr_wdata);

  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (wr_ok) begin
      if (wsel.mstatus) mstatus_d = wr_value;
      if (wsel.mtvec)   mtvec_d   = wr_value;
      if (wsel.mepc)    mepc_d    = wr_value;
      if (wsel.mcause)  mcause_d  = wr_value;
    end
    if (ecall_fire) begin
      mepc_d                                   = ecall_mepc;
      mcause_d                                 = ECALL_CAUSE;
      mstatus_d[MSTATUS_MPIE]                  = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]                   = 1'b0;
      mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end
    if (mret_fire) begin
      mstatus_d[MSTATUS_MIE]                   = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE]                  = 1'b1;
      mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    illegal_d     = (ecall_fire & (bus.WB_rv32_csrrw | bus.WB_rv32_csrrs | bus.WB_rv32_mret))
                  | (wr_en & (~wr_mapped | wsel.mvendorid | wsel.marchid));
    redir_valid_d = ecall_fire | mret_fire;
    redir_pc_d    = ecall_fire ? mtvec_q : (mret_fire ? mepc_q : redir_pc_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ecall_fire | mret_fire) state_d = REDIR;
      REDIR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Forwarding: a same-cycle commit is visible to EXU before it lands.
  always_comb begin
    bus.EXU_csr_rdata = '0;
    if (wr_en & rd_writable & (bus.WB_csr_addr == bus.EXU_csr_raddr)) begin
      bus.EXU_csr_rdata = wr_value;
    end else if (ecall_fire & rsel.mepc) begin
      bus.EXU_csr_rdata = ecall_mepc;
    end else if (ecall_fire & rsel.mcause) begin
      bus.EXU_csr_rdata = ECALL_CAUSE;
    end else if (rd_mapped) begin
      bus.EXU_csr_rdata = ({32{rsel.mstatus}}   & mstatus_q)
                        | ({32{rsel.mtvec}}     & mtvec_q)
                        | ({32{rsel.mepc}}      & mepc_q)
                        | ({32{rsel.mcause}}    & mcause_q)
                        | ({32{rsel.mvendorid}} & MVENDORID)
                        | ({32{rsel.marchid}}   & MARCHID);
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q     <= MSTATUS_RST;
      mtvec_q       <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      illegal_q     <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      mstatus_q     <= mstatus_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      illegal_q     <= illegal_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign bus.CSR_illegal        = illegal_q;
  assign bus.CSR_redirect_valid = redir_valid_q;
  assign bus.CSR_redirect_pc    = redir_pc_q;

endmodule

// File: doc/ysyx_23060136_wb_csr_file.md
Name: ysyx_23060136_wb_csr_file

Overview:
Machine-mode CSR register file at the WB end of the pipeline. It consumes the CSR write data computed in EXU (csrrw/csrrs result, or PC on ecall) and serves combinational CSR reads back to EXU, with write-to-read forwarding. It also registers the one-cycle trap/return redirect (ecall to mtvec, mret to mepc) for the PC generator.

Parameters:
MSTATUS_RST, 32'h0000_1800, reset value of mstatus (MPP=11)
MVENDORID, 32'h7973_7978, read-only value at 0xF11
MARCHID, 32'h015F_DEA8, read-only value at 0xF12
ECALL_CAUSE, 32'd11, mcause written on ecall (environment call from M-mode)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
WB_valid  in  1  WB instruction valid this cycle
WB_ready  out  1  CSR file can accept a commit this cycle
WB_csr_addr  in  12  CSR address for csrrw/csrrs commit
WB_csr_wdata  in  32  EXU CSR result (rs1|csr, rs1, or PC on ecall)
WB_rv32_csrrw  in  1  commit is csrrw
WB_rv32_csrrs  in  1  commit is csrrs
WB_rv32_ecall  in  1  commit is ecall; WB_csr_wdata is the ecall PC
WB_rv32_mret  in  1  commit is mret
EXU_csr_raddr  in  12  CSR read address from EXU
EXU_csr_rdata  out  32  CSR read data, forwarded
CSR_illegal  out  1  registered; pulses on a rejected write
CSR_redirect_valid  out  1  registered one-cycle redirect pulse
CSR_redirect_pc  out  32  redirect target, valid with CSR_redirect_valid

Behaviour:
- The storage is mstatus (0x300), mtvec (0x305), mepc (0x341) and mcause (0x342). 0xF11 and 0xF12 are constants. All other addresses read as 0.
- Reset (async) values:
  - mstatus = MSTATUS_RST; mtvec, mepc and mcause = 0.
  - CSR_redirect_valid, CSR_illegal and CSR_redirect_pc = 0.
  - State = IDLE.
- Commit: a commit fires when WB_valid & WB_ready. Exactly one of csrrw, csrrs, ecall or mret is expected to be set.
- csrrw and csrrs commits:
  - On the next edge the addressed CSR takes WB_csr_wdata.
  - mepc[1:0] and mtvec[1:0] are forced to 0 on write.
  - A write to a read-only address or an unmapped address is dropped, and CSR_illegal=1 on the next cycle.
- ecall commit, all on one edge:
  - mepc <= {WB_csr_wdata[31:2], 2'b00}; mcause <= ECALL_CAUSE.
  - mstatus.MPIE <= MIE; MIE <= 0; MPP <= 2'b11.
  - Next cycle: CSR_redirect_valid=1 and CSR_redirect_pc = mtvec (the value before the edge).
- mret commit:
  - mstatus.MIE <= MPIE; MPIE <= 1; MPP <= 2'b11.
  - Next cycle: CSR_redirect_valid=1 and CSR_redirect_pc = mepc.
- Conflicting flags: if ecall is set together with any other flag, ecall wins, the others are ignored, and CSR_illegal pulses.
- FSM states are IDLE and REDIR.
  - IDLE -> REDIR on an ecall or mret commit.
  - REDIR -> IDLE unconditionally after one cycle.
  - WB_ready = (state==IDLE), so a commit presented in REDIR stalls one cycle. This gives back-to-back ecalls one cycle of spacing, and the second ecall sees the updated CSRs.
- Read and forwarding:
  - EXU_csr_rdata is combinational.
  - If a csrrw/csrrs commit is firing this cycle to a writable address equal to EXU_csr_raddr, the read returns the masked WB_csr_wdata.
  - If an ecall is firing, reads of mepc and mcause return the values about to be written.
  - Otherwise the read returns the stored value.
- Pulses: CSR_redirect_valid and CSR_illegal are high for exactly one cycle per event. CSR_redirect_pc holds its last value when not valid.
- Reset mid-operation: reset asserted in REDIR clears the pulse immediately (async) and returns the FSM to IDLE. A commit present in the reset cycle is lost.
- No CSR side effects occur while WB_valid=0.

Decomposition:
- Shared package ysyx_23060136_CSR_PKG holds:
  - 12-bit CSR address localparams;
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11);
  - the ECALL_CAUSE default;
  - the IDLE/REDIR state enum.
- One sub-module, ysyx_23060136_wb_csr_decode: combinational address decode producing one-hot selects plus writable and mapped flags. It is shared by the read and write paths.

Test Plan:
- Reset release: read 0x300 -> 32'h1800; read 0x305/0x341/0x342 -> 0; read 0xF12 -> 32'h015FDEA8; all outputs 0.
- Write and forward: csrrw 0x305 with 32'h8000_0103, EXU_csr_raddr=0x305 in the same cycle -> rdata 32'h8000_0100 (bits [1:0] masked to 0); the next cycle reads the same value from storage.
- ecall (prerequisites mtvec=32'h8000_0100, mstatus=32'h1808): commit ecall with wdata 32'h8000_0024 -> next cycle redirect_valid=1, redirect_pc=32'h8000_0100, mepc=32'h8000_0024, mcause=11, mstatus=32'h1880; WB_ready=0 for that one cycle.
- mret after the ecall above -> mstatus=32'h1888; redirect_valid=1 with redirect_pc=32'h8000_0024; back-to-back commit stalled exactly 1 cycle.
- Illegal writes: csrrw to 0xF11 or 0x7C0 -> storage unchanged and CSR_illegal pulses 1 cycle; ecall+csrrw together -> ecall effects only, illegal pulse.
- Async reset asserted in REDIR between edges -> redirect_valid drops immediately, WB_ready=1, all CSRs back to reset values.
